mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// - Shares one single-ported instruction/data memory between the fetch port (I) and the load/store port (D) of the RISC-V core.
// - Sits between the core's fetch/LSU logic and the memory. Drives per-port ack/stall and supports variable-latency memory via mem_ready.
// - D has priority over I. A starvation counter forces an I grant after STARVE_LIMIT back-to-back D grants. A timeout aborts hung accesses.
// PARAMETERS
// - AW            32   address width
// - DW            32   data width (DW/8 byte enables)
// - STARVE_LIMIT  4    consecutive D grants allowed while i_req pending (1..15)
// - TIMEOUT       255  max cycles waiting for mem_ready before abort (1..255)
// PORTS
// - clk        in   1      core clock, rising edge
// - reset      in   1      synchronous, active-high
// - i_req      in   1      fetch request; held with i_addr until i_ack/i_err
// - i_addr     in   AW     fetch address
// - i_rdata    out  DW     fetch data, valid while i_ack=1
// - i_ack      out  1      1-cycle pulse: fetch done
// - i_err      out  1      1-cycle pulse: fetch timed out
// - d_req      in   1      load/store request; held with d_* until d_ack/d_err
// - d_we       in   1      1=store, 0=load
// - d_addr     in   AW     data address
// - d_wdata    in   DW     store data
// - d_be       in   DW/8   byte enables
// - d_rdata    out  DW     load data, valid while d_ack=1
// - d_ack      out  1      1-cycle pulse: access done
// - d_err      out  1      1-cycle pulse: access timed out
// - stall      out  1      (i_req|d_req) & no ack this cycle; core freezes PC/pipe
// - mem_req    out  1      memory strobe, held until mem_ready or abort
// - mem_we     out  1      memory write enable (0 for fetch)
// - mem_addr   out  AW     memory address
// - mem_wdata  out  DW     memory write data
// - mem_be     out  DW/8   byte enables (all 1s for fetch)
// - mem_ready  in   1      memory done; mem_rdata valid this cycle
// - mem_rdata  in   DW     memory read data
// BEHAVIOUR
// - FSM states: IDLE, BUSY_I, BUSY_D. All mem_* and ack/err outputs are registered.
// - Reset: state=IDLE. All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, mem_be, i_ack, d_ack, i_err, d_err, i_rdata, d_rdata. starve_cnt=0, tmo_cnt=0.
// - IDLE: arbitration uses the requests sampled at edge N. mem_req=1 with the winner's fields from N+1.
// - IDLE arbitration:
//   - d_req & !(i_req & starve_cnt==STARVE_LIMIT): grant D.
//   - else if i_req: grant I.
//   - else stay in IDLE.
// - starve_cnt: +1 on each D grant while i_req=1. Cleared on an I grant, or in any cycle with i_req=0. Saturates at STARVE_LIMIT.
// - BUSY_x: mem_* held stable, tmo_cnt +1 per cycle.
//   - mem_ready=1 at edge M: mem_req=0, x_ack=1, x_rdata=mem_rdata at M+1, state=IDLE at M+1.
//   - Next grant at M+1 drives mem_req at M+2. This gives 1 bubble cycle. Minimum access = 2 cycles from req to ack.
// - Timeout: tmo_cnt==TIMEOUT with mem_ready=0 -> mem_req=0, x_err=1 (x_ack=0) next cycle, state=IDLE. A late mem_ready in IDLE is ignored.
// - A requester dropping x_req mid-access is illegal. The access still completes and the ack is still issued.
// - Ack and err are mutually exclusive. At most one of i_ack, d_ack, i_err, d_err is high in any cycle.
// - Reset mid-access: next edge forces IDLE with all outputs 0. No ack/err is issued for the dropped access.
// - Address/data widths pass straight through, with no alignment checks (the LSU owns alignment).
// CONFIGURATION
// - ARB_PERF_CNT_EN defined:
//   - adds out ports i_stall_cnt[31:0] and d_stall_cnt[31:0].
//   - each counts cycles where its x_req=1 and x_ack=0.
//   - both cleared by reset, wrap at 2^32.
// - ARB_PERF_CNT_EN undefined: those ports and counters do not exist. Arbitration is identical in both builds.
// TESTING
// - Single fetch: i_req=1 with i_addr=0x10 at N; mem_ready=1 at N+1 with mem_rdata=0x00500093 -> mem_req=1 at N+1, i_ack=1 with i_rdata=0x00500093 at N+2.
// - Simultaneous: i_req=d_req=1 at N, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_be=4'hF, mem_ready after 1 cycle -> D served first (mem_we=1), d_ack precedes i_ack, then I served.
// - Starvation: d_req held continuously, i_req=1, STARVE_LIMIT=4 -> exactly 4 d_acks, then one i_ack, then D resumes.
// - Timeout: d_req=1 with mem_ready tied 0, TIMEOUT=8 -> d_err pulses once, no d_ack, mem_req=0 afterwards, FSM returns to IDLE and serves a later i_req normally.
// - Reset mid-access: assert reset while in BUSY_D -> next cycle mem_req=0, no ack/err. After release, a fresh i_req completes normally.
// - ARB_PERF_CNT_EN build: fetch with 3-cycle mem latency -> i_stall_cnt=4 after i_ack. Undefined build compiles without those ports.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between fetch (I) and load/store (D); D wins unless I is starved.
// Define ARB_PERF_CNT_EN to add per-port stall-cycle counters (i_stall_cnt, d_stall_cnt).
module mem_port_arbiter #(
   parameter int AW           = 32,
   parameter int DW           = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 255
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_req,
   input  logic [AW-1:0]   i_addr,
   output logic [DW-1:0]   i_rdata,
   output logic            i_ack,
   output logic            i_err,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [AW-1:0]   d_addr,
   input  logic [DW-1:0]   d_wdata,
   input  logic [DW/8-1:0] d_be,
   output logic [DW-1:0]   d_rdata,
   output logic            d_ack,
   output logic            d_err,
   output logic            stall,
   output logic            mem_req,
   output logic            mem_we,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   output logic [DW/8-1:0] mem_be,
   input  logic            mem_ready,
   input  logic [DW-1:0]   mem_rdata
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [31:0]     i_stall_cnt,
   output logic [31:0]     d_stall_cnt
`endif
);

   localparam int          BW         = DW / 8;
   localparam logic [3:0]  STARVE_MAX = 4'(STARVE_LIMIT);
   localparam logic [7:0]  TMO_MAX    = 8'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_e;

   state_e          state_q, state_d;
   logic            mem_req_q, mem_req_d;
   logic            mem_we_q, mem_we_d;
   logic [AW-1:0]   mem_addr_q, mem_addr_d;
   logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
   logic [BW-1:0]   mem_be_q, mem_be_d;
   logic            i_ack_q, i_ack_d;
   logic            d_ack_q, d_ack_d;
   logic            i_err_q, i_err_d;
   logic            d_err_q, d_err_d;
   logic [DW-1:0]   i_rdata_q, i_rdata_d;
   logic [DW-1:0]   d_rdata_q, d_rdata_d;
   logic [3:0]      starve_cnt_q, starve_cnt_d;
   logic [7:0]      tmo_cnt_q, tmo_cnt_d;
   logic            grant_i, grant_d;
`ifdef ARB_PERF_CNT_EN
   logic [31:0]     i_stall_cnt_q, i_stall_cnt_d;
   logic [31:0]     d_stall_cnt_q, d_stall_cnt_d;
`endif

   // Arbitration only happens in IDLE; D yields once I has watched STARVE_LIMIT D grants.
   always_comb begin
      grant_d = 1'b0;
      grant_i = 1'b0;
      if (state_q == IDLE) begin
         if (d_req && !(i_req && starve_cnt_q == STARVE_MAX)) grant_d = 1'b1;
         else if (i_req)                                       grant_i = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_be_d    = mem_be_q;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      tmo_cnt_d   = tmo_cnt_q;
      i_ack_d     = 1'b0;
      d_ack_d     = 1'b0;
      i_err_d     = 1'b0;
      d_err_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant_d) begin
               state_d     = BUSY_D;
               mem_req_d   = 1'b1;
               mem_we_d    = d_we;
               mem_addr_d  = d_addr;
               mem_wdata_d = d_wdata;
               mem_be_d    = d_be;
               tmo_cnt_d   = '0;
            end else if (grant_i) begin
               state_d     = BUSY_I;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = i_addr;
               mem_wdata_d = '0;
               mem_be_d    = '1;
               tmo_cnt_d   = '0;
            end
         end
         BUSY_I, BUSY_D: begin
            if (mem_ready) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               if (state_q == BUSY_I) begin
                  i_ack_d   = 1'b1;
                  i_rdata_d = mem_rdata;
               end else begin
                  d_ack_d   = 1'b1;
                  d_rdata_d = mem_rdata;
               end
            end else if (tmo_cnt_q == TMO_MAX) begin
               // Abort; a mem_ready arriving later lands in IDLE and is ignored.
               state_d   = IDLE;
               mem_req_d = 1'b0;
               if (state_q == BUSY_I) i_err_d = 1'b1;
               else                   d_err_d = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 8'd1;
            end
         end
         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   always_comb begin
      if (!i_req || grant_i)                           starve_cnt_d = '0;
      else if (grant_d && starve_cnt_q != STARVE_MAX)  starve_cnt_d = starve_cnt_q + 4'd1;
      else                                             starve_cnt_d = starve_cnt_q;
   end

`ifdef ARB_PERF_CNT_EN
   always_comb begin
      i_stall_cnt_d = i_stall_cnt_q;
      d_stall_cnt_d = d_stall_cnt_q;
      if (i_req && !i_ack_q) i_stall_cnt_d = i_stall_cnt_q + 32'd1;
      if (d_req && !d_ack_q) d_stall_cnt_d = d_stall_cnt_q + 32'd1;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_be_q     <= '0;
         i_ack_q      <= 1'b0;
         d_ack_q      <= 1'b0;
         i_err_q      <= 1'b0;
         d_err_q      <= 1'b0;
         i_rdata_q    <= '0;
         d_rdata_q    <= '0;
         starve_cnt_q <= '0;
         tmo_cnt_q    <= '0;
`ifdef ARB_PERF_CNT_EN
         i_stall_cnt_q <= '0;
         d_stall_cnt_q <= '0;
`endif
      end else begin
         state_q      <= state_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_be_q     <= mem_be_d;
         i_ack_q      <= i_ack_d;
         d_ack_q      <= d_ack_d;
         i_err_q      <= i_err_d;
         d_err_q      <= d_err_d;
         i_rdata_q    <= i_rdata_d;
         d_rdata_q    <= d_rdata_d;
         starve_cnt_q <= starve_cnt_d;
         tmo_cnt_q    <= tmo_cnt_d;
`ifdef ARB_PERF_CNT_EN
         i_stall_cnt_q <= i_stall_cnt_d;
         d_stall_cnt_q <= d_stall_cnt_d;
`endif
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_be    = mem_be_q;
   assign i_ack     = i_ack_q;
   assign d_ack     = d_ack_q;
   assign i_err     = i_err_q;
   assign d_err     = d_err_q;
   assign i_rdata   = i_rdata_q;
   assign d_rdata   = d_rdata_q;
   // Only an ack releases the core; an err cycle still reads as stalled.
   assign stall     = (i_req | d_req) & ~(i_ack_q | d_ack_q);
`ifdef ARB_PERF_CNT_EN
   assign i_stall_cnt = i_stall_cnt_q;
   assign d_stall_cnt = d_stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: requesters and a memory with chosen latency, checked against a
// transaction-timing model (grant edge, ack/err cycle = grant + latency arithmetic, starvation count).
module tb_mem_port_arbiter;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int SL  = 4;
   localparam int TMO = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          i_req, i_ack, i_err;
   logic [AW-1:0] i_addr;
   logic [DW-1:0] i_rdata;
   logic          d_req, d_we, d_ack, d_err;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata, d_rdata;
   logic [3:0]    d_be;
   logic          stall;
   logic          mem_req, mem_we, mem_ready;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic [3:0]    mem_be;
`ifdef ARB_PERF_CNT_EN
   logic [31:0]   i_stall_cnt, d_stall_cnt;
`endif

   always #5 clk = ~clk;

   mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(SL), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_err(i_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err), .stall(stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
`ifdef ARB_PERF_CNT_EN
      , .i_stall_cnt(i_stall_cnt), .d_stall_cnt(d_stall_cnt)
`endif
   );

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } txn_t;

   txn_t        iq[$], dq[$];
   logic [31:0] arr [16];
   int          n_cmp = 0, n_err = 0;
   int          cyc = 0, done_cyc = 0, starve = 0, force_lat = -1, max_gap = 0;
   int          i_gap = 0, d_gap = 0;
   bit          a_active = 0, a_tmo = 0, a_we = 0;
   int          a_port = 0, a_first = 0, a_lat = 0;
   logic [31:0] a_addr, a_wdata, a_rdata;
   logic [3:0]  a_be;
   bit          e_i_ack = 0, e_d_ack = 0, e_i_err = 0, e_d_err = 0;
   int          ack_log[$];
   int          i_ack_cyc = 0, i_present_cyc = 0, req_cycles = 0;
   logic [31:0] last_i_rdata, last_d_rdata, first_addr;
   logic        first_we;
   bit          first_seen = 0;
   logic [31:0] pc_i = 0, pc_d = 0;

   function automatic txn_t rand_txn(bit is_d);
      txn_t t;
      t.we    = is_d ? 1'($urandom_range(0, 1)) : 1'b0;
      t.addr  = $urandom;
      t.wdata = $urandom;
      t.be    = is_d ? 4'($urandom) : 4'hF;
      return t;
   endfunction

   function automatic txn_t mk(bit we, logic [31:0] addr, logic [31:0] wdata, logic [3:0] be);
      txn_t t;
      t.we = we; t.addr = addr; t.wdata = wdata; t.be = be;
      return t;
   endfunction

   function automatic bit busy();
      return (iq.size() > 0 || dq.size() > 0 || i_req || d_req || cyc < done_cyc);
   endfunction

   task automatic do_reset();
      reset = 1'b1; i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
      iq.delete(); dq.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      cyc++;
      done_cyc = cyc; starve = 0; a_active = 0;
      e_i_ack = 0; e_d_ack = 0; e_i_err = 0; e_d_err = 0;
      pc_i = 0; pc_d = 0; i_gap = 0; d_gap = 0;
   endtask

   task automatic step();
      bit s_i, s_d, e_mem, fin;
      int w;
      @(posedge clk); #1;
      cyc++;
      s_i = i_req; s_d = d_req;
      pc_i = pc_i + {31'b0, s_i & ~e_i_ack};
      pc_d = pc_d + {31'b0, s_d & ~e_d_ack};
      // Grant decided at the edge that ended the previous cycle, if the arbiter was idle then.
      w = 0;
      if (cyc - 1 >= done_cyc) begin
         if (s_d && !(s_i && starve == SL)) w = 2;
         else if (s_i)                      w = 1;
      end
      if (!s_i || w == 1)            starve = 0;
      else if (w == 2 && starve < SL) starve++;
      if (w != 0) begin
         a_active = 1; a_port = w; a_first = cyc;
         a_lat = (force_lat >= 0) ? force_lat :
                 (($urandom_range(0, 19) == 0) ? 12 : int'($urandom_range(0, 4)));
         a_tmo = (a_lat > TMO);
         done_cyc = a_tmo ? cyc + TMO + 1 : cyc + a_lat + 1;
         if (w == 2) begin
            a_we = d_we; a_addr = d_addr; a_wdata = d_wdata; a_be = d_be;
         end else begin
            a_we = 1'b0; a_addr = i_addr; a_wdata = '0; a_be = 4'hF;
         end
      end
      e_mem   = a_active && cyc < done_cyc;
      fin     = a_active && cyc == done_cyc;
      e_i_ack = fin && a_port == 1 && !a_tmo;
      e_d_ack = fin && a_port == 2 && !a_tmo;
      e_i_err = fin && a_port == 1 && a_tmo;
      e_d_err = fin && a_port == 2 && a_tmo;

      n_cmp++;
      if ({mem_req, i_ack, d_ack, i_err, d_err} !== {e_mem, e_i_ack, e_d_ack, e_i_err, e_d_err}) begin
         n_err++;
         $display("FAIL handshake cyc=%0d req/iack/dack/ierr/derr got=%b exp=%b", cyc,
                  {mem_req, i_ack, d_ack, i_err, d_err}, {e_mem, e_i_ack, e_d_ack, e_i_err, e_d_err});
      end
      if (e_mem) begin
         n_cmp++;
         if ({mem_we, mem_addr, mem_be} !== {a_we, a_addr, a_be}) begin
            n_err++;
            $display("FAIL mem_fields cyc=%0d got we=%b addr=%h be=%h exp we=%b addr=%h be=%h",
                     cyc, mem_we, mem_addr, mem_be, a_we, a_addr, a_be);
         end
         if (a_we) begin
            n_cmp++;
            if (mem_wdata !== a_wdata) begin
               n_err++;
               $display("FAIL mem_wdata cyc=%0d got=%h exp=%h", cyc, mem_wdata, a_wdata);
            end
         end
      end
      if (e_i_ack) begin
         n_cmp++;
         if (i_rdata !== a_rdata) begin
            n_err++;
            $display("FAIL i_rdata cyc=%0d got=%h exp=%h", cyc, i_rdata, a_rdata);
         end
      end
      if (e_d_ack && !a_we) begin
         n_cmp++;
         if (d_rdata !== a_rdata) begin
            n_err++;
            $display("FAIL d_rdata cyc=%0d got=%h exp=%h", cyc, d_rdata, a_rdata);
         end
      end
`ifdef ARB_PERF_CNT_EN
      n_cmp++;
      if (i_stall_cnt !== pc_i || d_stall_cnt !== pc_d) begin
         n_err++;
         $display("FAIL stall_cnt cyc=%0d got i=%0d d=%0d exp i=%0d d=%0d",
                  cyc, i_stall_cnt, d_stall_cnt, pc_i, pc_d);
      end
`endif
      if (i_ack === 1'b1) begin ack_log.push_back(1); i_ack_cyc = cyc; last_i_rdata = i_rdata; end
      if (d_ack === 1'b1) begin ack_log.push_back(2); last_d_rdata = d_rdata; end
      if (i_err === 1'b1) ack_log.push_back(3);
      if (d_err === 1'b1) ack_log.push_back(4);
      if (mem_req === 1'b1) begin
         req_cycles++;
         if (!first_seen) begin first_seen = 1; first_we = mem_we; first_addr = mem_addr; end
      end

      // Requesters: retire on ack/err, then present the next queued transaction after a gap.
      if (e_i_ack || e_i_err) begin
         void'(iq.pop_front()); i_req = 1'b0; i_gap = int'($urandom_range(0, max_gap));
      end
      if (e_d_ack || e_d_err) begin
         void'(dq.pop_front()); d_req = 1'b0; d_gap = int'($urandom_range(0, max_gap));
      end
      if (!i_req) begin
         if (iq.size() > 0 && i_gap == 0) begin
            i_req = 1'b1; i_addr = iq[0].addr; i_present_cyc = cyc;
         end else begin
            i_addr = $urandom;
            if (i_gap > 0) i_gap--;
         end
      end
      if (!d_req) begin
         if (dq.size() > 0 && d_gap == 0) begin
            d_req = 1'b1; d_we = dq[0].we; d_addr = dq[0].addr; d_wdata = dq[0].wdata; d_be = dq[0].be;
         end else begin
            d_we = 1'($urandom); d_addr = $urandom; d_wdata = $urandom; d_be = 4'($urandom);
            if (d_gap > 0) d_gap--;
         end
      end

      // Memory: answer on the chosen latency; stray readies only while the arbiter is idle.
      if (a_active && !a_tmo && cyc == a_first + a_lat) begin
         mem_ready = 1'b1;
         if (a_we) begin
            mem_rdata = $urandom;
            for (int b = 0; b < 4; b++)
               if (a_be[b]) arr[a_addr[5:2]][8*b +: 8] = a_wdata[8*b +: 8];
         end else begin
            mem_rdata = arr[a_addr[5:2]];
         end
         a_rdata = mem_rdata;
      end else begin
         mem_ready = !e_mem && ($urandom_range(0, 3) == 0);
         mem_rdata = $urandom;
      end
      #1;
      n_cmp++;
      if (stall !== ((i_req | d_req) & ~(e_i_ack | e_d_ack))) begin
         n_err++;
         $display("FAIL stall cyc=%0d got=%b exp=%b", cyc, stall, (i_req | d_req) & ~(e_i_ack | e_d_ack));
      end
   endtask

   task automatic run_idle(int maxc);
      int n = 0;
      while (busy() && n < maxc) begin step(); n++; end
      n_cmp++;
      if (busy()) begin
         n_err++;
         $display("FAIL run_bound got=%0d cycles still busy exp=done within %0d", n, maxc);
      end
   endtask

   task automatic check_log(string name, int exp[$]);
      bit ok;
      ok = (ack_log.size() == exp.size());
      if (ok) foreach (exp[k]) if (ack_log[k] != exp[k]) ok = 0;
      n_cmp++;
      if (!ok) begin
         n_err++;
         $display("FAIL %s got=%p exp=%p", name, ack_log, exp);
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be, i_ack, d_ack, i_err, d_err, i_rdata, d_rdata} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs got req=%b we=%b addr=%h be=%h acks=%b rd=%h/%h exp all 0",
                  mem_req, mem_we, mem_addr, mem_be, {i_ack, d_ack, i_err, d_err}, i_rdata, d_rdata);
      end
      n_cmp++;
      if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b exp=0", stall); end
   endtask

   task automatic test_single_fetch();
      force_lat = 0; max_gap = 0; ack_log.delete();
      arr[4] = 32'h0050_0093;
      iq.push_back(mk(1'b0, 32'h10, 32'h0, 4'hF));
      run_idle(50);
      check_log("single_acks", '{1});
      n_cmp++;
      if (i_ack_cyc - i_present_cyc != 2) begin
         n_err++; $display("FAIL single_latency got=%0d exp=2", i_ack_cyc - i_present_cyc);
      end
      n_cmp++;
      if (last_i_rdata !== 32'h0050_0093) begin
         n_err++; $display("FAIL single_rdata got=%h exp=00500093", last_i_rdata);
      end
   endtask

   task automatic test_simultaneous();
      force_lat = 1; ack_log.delete(); first_seen = 0;
      arr[8] = 32'h1234_5678;
      dq.push_back(mk(1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF));
      iq.push_back(mk(1'b0, 32'h20, 32'h0, 4'hF));
      dq.push_back(mk(1'b0, 32'h100, 32'h0, 4'hF));
      run_idle(80);
      n_cmp++;
      if (first_we !== 1'b1 || first_addr !== 32'h100) begin
         n_err++; $display("FAIL simul_first got we=%b addr=%h exp we=1 addr=00000100", first_we, first_addr);
      end
      check_log("simul_order", '{2, 2, 1});
      n_cmp++;
      if (last_d_rdata !== 32'hDEAD_BEEF) begin
         n_err++; $display("FAIL simul_readback got=%h exp=deadbeef", last_d_rdata);
      end
      n_cmp++;
      if (last_i_rdata !== 32'h1234_5678) begin
         n_err++; $display("FAIL simul_fetch got=%h exp=12345678", last_i_rdata);
      end
   endtask

   task automatic test_starvation();
      force_lat = 0; max_gap = 0; ack_log.delete();
      for (int k = 0; k < 6; k++) dq.push_back(mk(1'b0, $urandom, 32'h0, 4'hF));
      iq.push_back(mk(1'b0, $urandom, 32'h0, 4'hF));
      run_idle(100);
      check_log("starve_order", '{2, 2, 2, 2, 1, 2, 2});
   endtask

   task automatic test_timeout();
      force_lat = 100; max_gap = 0; ack_log.delete(); req_cycles = 0;
      dq.push_back(mk(1'b1, 32'h40, 32'hCAFE_F00D, 4'hF));
      run_idle(60);
      check_log("tmo_err", '{4});
      n_cmp++;
      if (req_cycles != TMO + 1) begin
         n_err++; $display("FAIL tmo_req_cycles got=%0d exp=%0d", req_cycles, TMO + 1);
      end
      step(); step();
      n_cmp++;
      if (mem_req !== 1'b0) begin n_err++; $display("FAIL tmo_req_low got=%b exp=0", mem_req); end
      force_lat = 0;
      iq.push_back(mk(1'b0, 32'h44, 32'h0, 4'hF));
      run_idle(50);
      check_log("tmo_then_fetch", '{4, 1});
   endtask

   task automatic test_reset_mid();
      force_lat = 50; max_gap = 0;
      dq.push_back(mk(1'b0, 32'h80, 32'h0, 4'hF));
      for (int k = 0; k < 4; k++) step();
      n_cmp++;
      if (mem_req !== 1'b1) begin n_err++; $display("FAIL rstmid_busy got=%b exp=1", mem_req); end
      ack_log.delete();
      do_reset();
      n_cmp++;
      if ({mem_req, mem_we, mem_addr, mem_be, i_ack, d_ack, i_err, d_err} !== '0) begin
         n_err++; $display("FAIL rstmid_outputs got req=%b acks=%b addr=%h exp all 0",
                           mem_req, {i_ack, d_ack, i_err, d_err}, mem_addr);
      end
      force_lat = 0;
      iq.push_back(mk(1'b0, 32'h14, 32'h0, 4'hF));
      run_idle(50);
      check_log("rstmid_fetch", '{1});
      n_cmp++;
      if (last_i_rdata !== arr[5]) begin
         n_err++; $display("FAIL rstmid_rdata got=%h exp=%h", last_i_rdata, arr[5]);
      end
   endtask

   task automatic test_random();
      force_lat = -1; max_gap = 2; ack_log.delete();
      for (int k = 0; k < 150; k++) begin
         iq.push_back(rand_txn(1'b0));
         dq.push_back(rand_txn(1'b1));
      end
      run_idle(20000);
      n_cmp++;
      if (ack_log.size() != 300) begin
         n_err++; $display("FAIL random_completions got=%0d exp=300", ack_log.size());
      end
   endtask

`ifdef ARB_PERF_CNT_EN
   task automatic test_perf();
      do_reset();
      force_lat = 2; max_gap = 0;
      iq.push_back(mk(1'b0, 32'h8, 32'h0, 4'hF));
      run_idle(50);
      n_cmp++;
      if (i_stall_cnt !== 32'd4) begin
         n_err++; $display("FAIL perf_i_stall got=%0d exp=4", i_stall_cnt);
      end
   endtask
`endif

   initial begin
      reset = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      i_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0;
      mem_ready = 1'b0; mem_rdata = '0;
      for (int k = 0; k < 16; k++) arr[k] = $urandom;
      test_reset();
      test_single_fetch();
      test_simultaneous();
      test_starvation();
      test_timeout();
      test_reset_mid();
      test_random();
`ifdef ARB_PERF_CNT_EN
      test_perf();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
